// File: rtl/rcc_pkg.sv
// Shared types, select encodings and helpers for the clock-select sequencer.
package rcc_pkg;

    typedef enum logic [1:0] {
        SRC_A = 2'd0,
        SRC_B = 2'd1,
        SRC_C = 2'd2
    } clk_src_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_SETTLE   = 2'd3
    } sel_ctrl_state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    function automatic logic [1:0] src2sel(input logic [1:0] src);
        logic [1:0] sel;
        case (src)
            SRC_A:   sel = SEL_A;
            SRC_B:   sel = SEL_B;
            SRC_C:   sel = SEL_C;
            default: sel = SEL_A;
        endcase
        return sel;
    endfunction

    // Counter width for a count limit, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rcc_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset to 0.
module rcc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_ff[STAGES-1];

endmodule

// File: rtl/rcc_clk_sel_ctrl.sv
// Clock-source select sequencer driving the glitch-free mux select.
// Optional macro RCC_AUTO_FALLBACK_EN: fall back to RESET_SRC when the current source loses ready.
module rcc_clk_sel_ctrl
    import rcc_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int RESET_SRC      = 0
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            req_valid_i,
    input  logic [1:0]      req_src_i,
    output logic            req_ready_o,
    input  logic [2:0]      src_rdy_i,
    output logic [1:0]      sel_o,
    output logic [1:0]      cur_src_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output sel_ctrl_state_e dbg_state_o
);

    localparam int         TW         = cnt_width(TIMEOUT_CYCLES);
    localparam int         SW         = cnt_width(SETTLE_CYCLES);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [1:0] RESET_CODE = 2'(RESET_SRC);

    logic [2:0] rdy_s;

    for (genvar g = 0; g < 3; g++) begin : g_sync
        rcc_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .d_i    (src_rdy_i[g]),
            .q_o    (rdy_s[g])
        );
    end

    sel_ctrl_state_e state_q, state_d;
    logic [1:0]      target_q, target_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      cur_q, cur_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            fallback_hit;

`ifdef RCC_AUTO_FALLBACK_EN
    assign fallback_hit = (state_q == ST_IDLE) && !rdy_s[cur_q] && (cur_q != RESET_CODE);
`else
    assign fallback_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        sel_d    = sel_q;
        cur_d    = cur_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A lost current source pre-empts any pending request.
                if (fallback_hit) begin
                    err_d    = 1'b1;
                    target_d = RESET_CODE;
                    timer_d  = '0;
                    state_d  = ST_WAIT_RDY;
                end else if (req_valid_i) begin
                    if (req_src_i == 2'd3) begin
                        err_d = 1'b1;
                    end else if (req_src_i == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = req_src_i;
                        timer_d  = '0;
                        state_d  = ST_WAIT_RDY;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (rdy_s[target_q]) begin
                    state_d = ST_SWITCH;
                end else if (timer_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SWITCH: begin
                sel_d    = src2sel(target_q);
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    cur_d   = target_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            target_q <= RESET_CODE;
            timer_q  <= '0;
            settle_q <= '0;
            sel_q    <= src2sel(RESET_CODE);
            cur_q    <= RESET_CODE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            cur_q    <= cur_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Handshake: a request is consumed on a clock edge where req_valid_i && req_ready_o.
    assign req_ready_o = (state_q == ST_IDLE) && !fallback_hit;
    assign busy_o      = (state_q != ST_IDLE);
    assign sel_o       = sel_q;
    assign cur_src_o   = cur_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rcc_clk_sel_ctrl.sv
// Directed bench for rcc_clk_sel_ctrl (TIMEOUT_CYCLES=16, other parameters default).
module tb_rcc_clk_sel_ctrl;
    import rcc_pkg::*;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic            req_valid_i;
    logic [1:0]      req_src_i;
    logic            req_ready_o;
    logic [2:0]      src_rdy_i;
    logic [1:0]      sel_o;
    logic [1:0]      cur_src_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    sel_ctrl_state_e dbg_state_o;

    int checks = 0;
    int errors = 0;

    rcc_clk_sel_ctrl #(
        .SYNC_STAGES    (2),
        .SETTLE_CYCLES  (8),
        .TIMEOUT_CYCLES (16),
        .RESET_SRC      (0)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_src_i   (req_src_i),
        .req_ready_o (req_ready_o),
        .src_rdy_i   (src_rdy_i),
        .sel_o       (sel_o),
        .cur_src_o   (cur_src_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn_i      = 1'b0;
        req_valid_i = 1'b0;
        req_src_i   = 2'd0;
        src_rdy_i   = 3'b111;

        // Reset state
        #3;
        check("rst_sel", 32'(sel_o), 32'h0);
        check("rst_cur", 32'(cur_src_o), 32'h0);
        check("rst_ready", 32'(req_ready_o), 32'h1);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #2 rstn_i = 1'b1;
        steps(3);

        // Switch A -> C with C ready
        req_valid_i = 1'b1;
        req_src_i   = 2'd2;
        step();
        check("c_busy_t", 32'(busy_o), 32'h1);
        check("c_ready_t", 32'(req_ready_o), 32'h0);
        check("c_state_wait", 32'(dbg_state_o), 32'(ST_WAIT_RDY));
        req_valid_i = 1'b0;
        step();
        check("c_sel_t1", 32'(sel_o), 32'h0);
        check("c_state_switch", 32'(dbg_state_o), 32'(ST_SWITCH));
        step();
        check("c_sel_t2", 32'(sel_o), 32'h2);
        check("c_busy_t2", 32'(busy_o), 32'h1);
        steps(7);
        check("c_done_t9", 32'(done_o), 32'h0);
        check("c_busy_t9", 32'(busy_o), 32'h1);
        check("c_cur_t9", 32'(cur_src_o), 32'h0);
        step();
        check("c_done_t10", 32'(done_o), 32'h1);
        check("c_cur_t10", 32'(cur_src_o), 32'h2);
        check("c_busy_t10", 32'(busy_o), 32'h0);
        check("c_ready_t10", 32'(req_ready_o), 32'h1);
        step();
        check("c_done_t11", 32'(done_o), 32'h0);

        // Timeout on B never ready
        src_rdy_i = 3'b101;
        steps(3);
        req_valid_i = 1'b1;
        req_src_i   = 2'd1;
        step();
        req_valid_i = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            check("to_err_low", 32'(err_o), 32'h0);
            check("to_busy", 32'(busy_o), 32'h1);
        end
        step();
        check("to_err", 32'(err_o), 32'h1);
        check("to_done", 32'(done_o), 32'h0);
        check("to_sel", 32'(sel_o), 32'h2);
        check("to_cur", 32'(cur_src_o), 32'h2);
        check("to_ready", 32'(req_ready_o), 32'h1);
        step();
        check("to_err_end", 32'(err_o), 32'h0);

        // Invalid source, then request for the current source
        req_valid_i = 1'b1;
        req_src_i   = 2'd3;
        step();
        req_valid_i = 1'b0;
        check("inv_err", 32'(err_o), 32'h1);
        check("inv_done", 32'(done_o), 32'h0);
        check("inv_busy", 32'(busy_o), 32'h0);
        check("inv_sel", 32'(sel_o), 32'h2);
        step();
        check("inv_err_end", 32'(err_o), 32'h0);
        req_valid_i = 1'b1;
        req_src_i   = 2'd2;
        step();
        req_valid_i = 1'b0;
        check("same_done", 32'(done_o), 32'h1);
        check("same_err", 32'(err_o), 32'h0);
        check("same_sel", 32'(sel_o), 32'h2);
        check("same_busy", 32'(busy_o), 32'h0);
        step();
        check("same_done_end", 32'(done_o), 32'h0);

        // Held request during SETTLE, then reset mid-SETTLE
        src_rdy_i = 3'b111;
        steps(3);
        req_valid_i = 1'b1;
        req_src_i   = 2'd0;
        step();
        req_src_i = 2'd1;
        steps(2);
        check("hold_sel_a", 32'(sel_o), 32'h0);
        for (int i = 0; i < 7; i++) begin
            check("hold_ready", 32'(req_ready_o), 32'h0);
            step();
        end
        step();
        check("hold_done", 32'(done_o), 32'h1);
        check("hold_cur", 32'(cur_src_o), 32'h0);
        check("hold_ready_idle", 32'(req_ready_o), 32'h1);
        step();
        check("hold_accept_busy", 32'(busy_o), 32'h1);
        check("hold_accept_done", 32'(done_o), 32'h0);
        req_valid_i = 1'b0;
        steps(2);
        check("hold_sel_b", 32'(sel_o), 32'h1);
        steps(2);
        check("hold_state_settle", 32'(dbg_state_o), 32'(ST_SETTLE));
        #2 rstn_i = 1'b0;
        #1;
        check("mid_rst_sel", 32'(sel_o), 32'h0);
        check("mid_rst_cur", 32'(cur_src_o), 32'h0);
        check("mid_rst_busy", 32'(busy_o), 32'h0);
        check("mid_rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
        #3 rstn_i = 1'b1;
        steps(3);

        // Move to C, then lose C with a simultaneous request for B
        req_valid_i = 1'b1;
        req_src_i   = 2'd2;
        step();
        req_valid_i = 1'b0;
        steps(10);
        check("fb_pre_done", 32'(done_o), 32'h1);
        check("fb_pre_cur", 32'(cur_src_o), 32'h2);
        step();
        src_rdy_i = 3'b011;
        steps(2);
        req_valid_i = 1'b1;
        req_src_i   = 2'd1;
`ifdef RCC_AUTO_FALLBACK_EN
        check("fb_ready_blocked", 32'(req_ready_o), 32'h0);
        step();
        check("fb_err", 32'(err_o), 32'h1);
        check("fb_err_done", 32'(done_o), 32'h0);
        check("fb_busy", 32'(busy_o), 32'h1);
        steps(2);
        check("fb_sel_a", 32'(sel_o), 32'h0);
        steps(8);
        check("fb_done", 32'(done_o), 32'h1);
        check("fb_cur", 32'(cur_src_o), 32'h0);
        check("fb_ready_after", 32'(req_ready_o), 32'h1);
        step();
        check("fb_req_accept", 32'(busy_o), 32'h1);
        req_valid_i = 1'b0;
        steps(2);
        check("fb_req_sel_b", 32'(sel_o), 32'h1);
        steps(8);
        check("fb_req_done", 32'(done_o), 32'h1);
        check("fb_req_cur", 32'(cur_src_o), 32'h1);
`else
        check("nofb_ready", 32'(req_ready_o), 32'h1);
        step();
        check("nofb_err", 32'(err_o), 32'h0);
        check("nofb_busy", 32'(busy_o), 32'h1);
        req_valid_i = 1'b0;
        steps(2);
        check("nofb_sel_b", 32'(sel_o), 32'h1);
        steps(8);
        check("nofb_done", 32'(done_o), 32'h1);
        check("nofb_cur", 32'(cur_src_o), 32'h1);
`endif
        step();
        check("end_done", 32'(done_o), 32'h0);
        check("end_busy", 32'(busy_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcc_clk_sel_ctrl.md
Name: rcc_clk_sel_ctrl

Overview:
- Sequencer directly upstream of the 3-input glitch-free clock mux; the only block that drives the mux's 2-bit select.
- Accepts a clock-source request (A/B/C) from the register interface and waits until the target oscillator/PLL reports ready.
- Drives the select, holds through a settle window, then reports completion or error.
- Runs on the always-on reference clock, never on the muxed output.

Parameters:
- SYNC_STAGES, 2, flops per ready-bit synchronizer (min 2)
- SETTLE_CYCLES, 8, clk_i cycles held after a select change before completion (min 1)
- TIMEOUT_CYCLES, 256, max clk_i cycles waiting for target ready (min 2)
- RESET_SRC, 0, source selected out of reset (0=A, 1=B, 2=C)

Ports:
- clk_i  input  1  always-on reference clock
- rstn_i  input  1  asynchronous active-low reset
- req_valid_i  input  1  switch request valid; held until accepted
- req_src_i  input  2  requested source: 0=A, 1=B, 2=C, 3=invalid
- req_ready_o  output  1  request accepted when req_valid_i && req_ready_o
- src_rdy_i  input  3  per-source ready/lock, asynchronous; bit0=A, bit1=B, bit2=C
- sel_o  output  2  to mux select; A=2'b00, B=2'b01, C=2'b10
- cur_src_o  output  2  committed source code
- busy_o  output  1  switch in progress
- done_o  output  1  one-cycle pulse: request completed
- err_o  output  1  one-cycle pulse: invalid request or timeout

Behaviour:
- Clocking and reset: single clock clk_i; reset is asynchronous and active-low on rstn_i.
- Reset values:
  - sel_o = src2sel(RESET_SRC); cur_src_o = RESET_SRC
  - busy_o = 0; done_o = 0; err_o = 0
  - state = IDLE, so req_ready_o = 1
  - synchronizer flops = 0; all counters = 0
- Ready inputs: each src_rdy_i bit passes through SYNC_STAGES flops to give rdy_s[2:0]. The FSM uses only rdy_s.
- Outputs: all registered except req_ready_o = (state==IDLE) && !fallback_hit; fallback_hit is always 0 without the macro. busy_o = (state!=IDLE).
- FSM states: IDLE, WAIT_RDY, SWITCH, SETTLE.
- IDLE, request accepted on edge T:
  - req_src_i==3: err_o=1 for the cycle after T; stay IDLE.
  - req_src_i==cur_src_o: done_o=1 for the cycle after T; no select change.
  - Otherwise: latch target, clear timer, go to WAIT_RDY.
- WAIT_RDY:
  - rdy_s[target]=1: go to SWITCH.
  - Otherwise the timer increments. If the timer reaches TIMEOUT_CYCLES-1 with ready still low: err_o pulse, go to IDLE; sel_o and cur_src_o unchanged.
- SWITCH: register sel_o <= src2sel(target); clear settle counter; go to SETTLE. Lasts exactly one cycle.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then cur_src_o <= target, done_o pulse, go to IDLE.
  - A drop of rdy_s[target] during SETTLE is ignored.
- Latency, target already synced ready:
  - accept edge T
  - SWITCH at edge T+1
  - sel_o changes at edge T+2
  - done_o high in the cycle after edge T+2+SETTLE_CYCLES
- Requests while busy: req_ready_o=0; the request is not consumed. The requester holds valid.
- sel_o changes only in SWITCH, and only once per switch.
- done_o and err_o are never high in the same cycle.
- Reset mid-operation: all state returns asynchronously to reset values. The mux shares rstn_i.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Optional Feature:
- Macro: RCC_AUTO_FALLBACK_EN
- With the macro:
  - In IDLE, if rdy_s[cur_src_o]==0 and cur_src_o!=RESET_SRC, fallback_hit=1.
  - err_o pulses and an internal switch to RESET_SRC starts via WAIT_RDY/SWITCH/SETTLE; done_o pulses on completion.
  - Fallback beats a simultaneous request: req_ready_o=0 that cycle and the request is not consumed.
- Without the macro: loss of the current source's ready is ignored.

Decomposition:
- Package rcc_pkg:
  - clk_src_e enum: SRC_A=0, SRC_B=1, SRC_C=2
  - sel_ctrl_state_e
  - SEL_A/SEL_B/SEL_C constants
  - function src2sel
- Sub-module rcc_sync: single-bit synchronizer, parameter STAGES, async active-low reset to 0. Three instances, one per ready bit.

Test Plan:
- Reset with RESET_SRC=0, src_rdy_i=3'b111 -> sel_o=00, cur_src_o=0, req_ready_o=1, busy_o=0, done_o=0, err_o=0.
- Request req_src_i=2 with C ready, defaults -> sel_o=10 two edges after acceptance; done_o one cycle, 10 edges after acceptance; cur_src_o=2; busy_o high throughout.
- req_src_i=1 with src_rdy_i[1]=0, TIMEOUT_CYCLES=16 -> err_o pulse after 16 WAIT_RDY cycles; sel_o stays 00; req_ready_o returns to 1.
- req_src_i=3, then req_src_i=cur_src_o -> err_o pulse, then done_o pulse; sel_o never toggles.
- New request held during SETTLE -> req_ready_o=0 until IDLE; accepted on the first IDLE cycle; assert rstn_i low mid-SETTLE -> sel_o immediately 00.
- RCC_AUTO_FALLBACK_EN, cur_src_o=2, drop src_rdy_i[2] with a simultaneous request for 1 -> err_o pulse; fallback to A with sel_o=00 and done_o; the request is accepted afterwards.
